// File: rtl/sw_ctrl_core_if.sv
// Button pulses in, display/status out for the stopwatch control core.
interface sw_ctrl_core_if;
    logic        det0;
    logic        det1;
    logic        det2;
    logic [23:0] disp_time;
    logic        running;
    logic        lap_act;
    logic        tick;
    logic        ovf;

    modport master (
        output det0, det1, det2,
        input  disp_time, running, lap_act, tick, ovf
    );

    modport slave (
        input  det0, det1, det2,
        output disp_time, running, lap_act, tick, ovf
    );
endinterface

// File: rtl/sw_ctrl_core.sv
// Stopwatch control: mode FSM, centisecond prescaler, BCD MM:SS:CC counter
// and lap-freeze display register.
module sw_ctrl_core #(
    parameter int unsigned DIV = 500000
) (
    input  logic           mclk,
    input  logic           rst_n,
    sw_ctrl_core_if.slave  bus
);

    localparam int unsigned PW         = $clog2(DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
    // Highest legal value of each BCD digit, least significant digit first.
    localparam logic [23:0] DIGIT_MAX  = 24'h995999;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, LAP} state_t;

    state_t        state;
    logic [PW-1:0] presc;
    logic [23:0]   live;
    logic [23:0]   lap;
    logic [23:0]   live_inc;
    logic [23:0]   live_adv;
    logic          carry;
    logic          wrap;
    logic          count_en;
    logic          term;

    // Ripple BCD increment; carry out of the top digit means 99:59:99 wrapped.
    always_comb begin
        live_inc = live;
        carry    = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (carry) begin
                if (live[i*4 +: 4] == DIGIT_MAX[i*4 +: 4]) begin
                    live_inc[i*4 +: 4] = 4'd0;
                end else begin
                    live_inc[i*4 +: 4] = live[i*4 +: 4] + 4'd1;
                    carry              = 1'b0;
                end
            end
        end
        wrap = carry;
    end

    assign count_en = (state == RUN) || (state == LAP);
    assign term     = count_en && (presc == PRESC_LAST);
    assign live_adv = term ? live_inc : live;

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            presc         <= '0;
            live          <= '0;
            lap           <= '0;
            bus.disp_time <= '0;
            bus.running   <= 1'b0;
            bus.lap_act   <= 1'b0;
            bus.tick      <= 1'b0;
            bus.ovf       <= 1'b0;
        end else begin
            bus.tick      <= term;
            bus.ovf       <= term && wrap;
            live          <= live_adv;
            bus.disp_time <= bus.lap_act ? lap : live_adv;
            if (count_en) begin
                presc <= term ? '0 : PW'(presc + 1'b1);
            end

            // Later assignments override the hold-state defaults above.
            case (state)
                IDLE: begin
                    if (bus.det0) begin
                        state       <= RUN;
                        bus.running <= 1'b1;
                    end
                end
                RUN: begin
                    if (bus.det0) begin
                        state       <= PAUSE;
                        bus.running <= 1'b0;
                    end else if (bus.det1) begin
                        state         <= LAP;
                        bus.lap_act   <= 1'b1;
                        lap           <= live;
                        bus.disp_time <= live;
                    end
                end
                LAP: begin
                    if (bus.det0) begin
                        state         <= PAUSE;
                        bus.running   <= 1'b0;
                        bus.lap_act   <= 1'b0;
                        bus.disp_time <= live_adv;
                    end else if (bus.det1) begin
                        state         <= RUN;
                        bus.lap_act   <= 1'b0;
                        bus.disp_time <= live_adv;
                    end
                end
                PAUSE: begin
                    if (bus.det2) begin
                        state         <= IDLE;
                        live          <= '0;
                        presc         <= '0;
                        bus.disp_time <= '0;
                    end else if (bus.det0) begin
                        state       <= RUN;
                        bus.running <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sw_ctrl_core.sv
// Bench for sw_ctrl_core: integer-centisecond reference model compared every
// cycle, directed scenarios with literal expectations, then random pulses.
module tb_sw_ctrl_core;

    localparam int DIV     = 4;
    localparam int FULL    = 600000;   // centiseconds in 100 minutes
    localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_PAUSE = 2'd2, S_LAP = 2'd3;

    typedef struct packed {
        logic [1:0] st;
        int         presc;
        int         live;
        int         lap;
        logic       tick;
        logic       ovf;
    } mstate_t;

    logic mclk  = 1'b0;
    logic rst_n = 1'b0;
    logic load_req = 1'b0;
    int   load_val = 0;
    int   n_tests  = 0;
    int   n_fail   = 0;
    mstate_t m;

    sw_ctrl_core_if bus ();

    sw_ctrl_core #(.DIV(DIV)) dut (
        .mclk  (mclk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 mclk = ~mclk;

    function automatic logic [23:0] to_bcd(input int cs);
        int mi = cs / 6000;
        int se = (cs / 100) % 60;
        int c  = cs % 100;
        return {4'(mi / 10), 4'(mi % 10), 4'(se / 10), 4'(se % 10), 4'(c / 10), 4'(c % 10)};
    endfunction

    function automatic mstate_t model_next(input mstate_t s, input logic d0, input logic d1,
                                           input logic d2, input logic ld, input int ldv);
        mstate_t n = s;
        n.tick = 1'b0;
        n.ovf  = 1'b0;
        if (s.st == S_RUN || s.st == S_LAP) begin
            if (s.presc == DIV - 1) begin
                n.presc = 0;
                n.tick  = 1'b1;
                n.live  = (s.live + 1) % FULL;
                n.ovf   = (s.live == FULL - 1);
            end else begin
                n.presc = s.presc + 1;
            end
        end
        case (s.st)
            S_IDLE:  if (d0) n.st = S_RUN;
            S_RUN:   if (d0) n.st = S_PAUSE;
                     else if (d1) begin n.st = S_LAP; n.lap = s.live; end
            S_LAP:   if (d0) n.st = S_PAUSE;
                     else if (d1) n.st = S_RUN;
            default: if (d2) begin n.st = S_IDLE; n.live = 0; n.presc = 0; end
                     else if (d0) n.st = S_RUN;
        endcase
        if (ld) n.live = ldv;
        return n;
    endfunction

    always @(posedge mclk or negedge rst_n) begin
        if (!rst_n) m <= '0;
        else        m <= model_next(m, bus.det0, bus.det1, bus.det2, load_req, load_val);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic [23:0] e_disp;
        e_disp = (m.st == S_LAP) ? to_bcd(m.lap) : to_bcd(m.live);
        chk("disp_time", 32'(bus.disp_time), 32'(e_disp));
        chk("running",   32'(bus.running),   32'(m.st == S_RUN || m.st == S_LAP));
        chk("lap_act",   32'(bus.lap_act),   32'(m.st == S_LAP));
        chk("tick",      32'(bus.tick),      32'(m.tick));
        chk("ovf",       32'(bus.ovf),       32'(m.ovf));
    endtask

    // Advance one cycle; compare at the falling edge, away from the active edge.
    task automatic cyc();
        @(negedge mclk);
        if (rst_n) compare_all();
    endtask

    task automatic pulse(input logic d0, input logic d1, input logic d2);
        bus.det0 = d0; bus.det1 = d1; bus.det2 = d2;
        cyc();
        bus.det0 = 1'b0; bus.det1 = 1'b0; bus.det2 = 1'b0;
    endtask

    task automatic wait_tick(input string nm, output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (!bus.tick && n < 40);
        chk(nm, 32'(bus.tick), 32'd1);
    endtask

    initial begin
        int k;
        bus.det0 = 1'b0; bus.det1 = 1'b0; bus.det2 = 1'b0;
        repeat (3) @(negedge mclk);
        rst_n = 1'b1;
        chk("rst_disp", 32'(bus.disp_time), 32'h0);
        chk("rst_running", 32'(bus.running), 32'h0);

        // Idle with stray lap/clear pulses: nothing moves.
        for (int i = 0; i < 100; i++) begin
            bus.det1 = 1'($urandom_range(0, 1));
            bus.det2 = 1'($urandom_range(0, 1));
            cyc();
        end
        bus.det1 = 1'b0; bus.det2 = 1'b0;
        chk("idle_disp", 32'(bus.disp_time), 32'h0);

        // Start and run one second.
        bus.det0 = 1'b1;
        cyc();
        bus.det0 = 1'b0;
        chk("start_running", 32'(bus.running), 32'd1);
        repeat (400) cyc();
        chk("one_second", 32'(bus.disp_time), 32'h000100);
        chk("one_second_tick", 32'(bus.tick), 32'd1);

        // Pause with prescaler at 2, hold, resume: tick two edges later.
        cyc();
        pulse(1'b1, 1'b0, 1'b0);
        chk("pause_running", 32'(bus.running), 32'd0);
        repeat (50) cyc();
        chk("pause_hold", 32'(bus.disp_time), 32'h000100);
        pulse(1'b1, 1'b0, 1'b0);
        k = 1;
        while (!bus.tick && k < 10) begin
            cyc();
            k++;
        end
        chk("resume_tick_latency", 32'(k), 32'd3);
        chk("resume_disp", 32'(bus.disp_time), 32'h000101);

        // Clear, restart, lap at 00:00:10.
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b1);
        chk("clear_disp", 32'(bus.disp_time), 32'h0);
        pulse(1'b1, 1'b0, 1'b0);
        k = 0;
        while (bus.disp_time != 24'h000010 && k < 200) begin
            cyc();
            k++;
        end
        chk("reach_10", 32'(bus.disp_time), 32'h000010);
        pulse(1'b0, 1'b1, 1'b0);
        chk("lap_act", 32'(bus.lap_act), 32'd1);
        repeat (30) cyc();
        chk("lap_frozen", 32'(bus.disp_time), 32'h000010);
        pulse(1'b0, 1'b1, 1'b0);
        chk("lap_release", 32'(bus.lap_act), 32'd0);
        chk("lap_release_live", 32'(bus.disp_time), 32'h000018);

        // Preload 99:59:98 while paused, then roll over.
        pulse(1'b1, 1'b0, 1'b0);
        force dut.live = 24'h995998;
        load_req = 1'b1;
        load_val = FULL - 2;
        cyc();
        release dut.live;
        load_req = 1'b0;
        chk("preload", 32'(bus.disp_time), 32'h995998);
        pulse(1'b1, 1'b0, 1'b0);
        wait_tick("tick_a", k);
        chk("pre_wrap", 32'(bus.disp_time), 32'h995999);
        chk("pre_wrap_ovf", 32'(bus.ovf), 32'd0);
        wait_tick("tick_b", k);
        chk("wrap", 32'(bus.disp_time), 32'h000000);
        chk("wrap_ovf", 32'(bus.ovf), 32'd1);
        cyc();
        chk("ovf_one_cycle", 32'(bus.ovf), 32'd0);

        // Pause then simultaneous start/stop + clear goes to IDLE.
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b1);
        chk("combo_clear", 32'(bus.disp_time), 32'h0);
        chk("combo_running", 32'(bus.running), 32'd0);

        // Asynchronous reset mid-run.
        pulse(1'b1, 1'b0, 1'b0);
        repeat (23) cyc();
        chk("pre_reset_nonzero", 32'(bus.disp_time != 24'h0), 32'd1);
        @(posedge mclk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_disp", 32'(bus.disp_time), 32'h0);
        chk("async_running", 32'(bus.running), 32'd0);
        chk("async_lap", 32'(bus.lap_act), 32'd0);
        chk("async_tick", 32'(bus.tick), 32'd0);
        @(negedge mclk);
        rst_n = 1'b1;

        // Random pulse traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            bus.det0 = (r < 4) || (r == 50);
            bus.det1 = (r >= 4 && r < 9) || (r == 50);
            bus.det2 = (r >= 9 && r < 13) || (r == 50);
            cyc();
        end
        bus.det0 = 1'b0; bus.det1 = 1'b0; bus.det2 = 1'b0;
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
